// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_ctrl
//  Description : Multiply/divide sequencer that owns every HI/LO write.
//                MULT/MULTU use a registered 32x32 product (2 stall cycles).
//                DIV/DIVU use a radix-2 restoring divider (32 steps) with sign
//                fix-up. MTHI/MTLO write in the request cycle. A cancel flushes
//                everything without a write.
//  Ports       : clk, reset (async, active-high)
//                start/op/src_a/src_b : request from EX
//                cancel               : exception/ERET flush
//                hi_in/lo_in          : current HI/LO contents
//                hilo_wdata/hilo_wen  : write port toward hilo_reg
//                stall                : combinational pipeline hold
//                busy                 : sequencer not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [63:0] hilo_wdata,
    output logic        hilo_wen,
    output logic        stall,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] C_OP_MULT  = 3'd1;
    localparam logic [2:0] C_OP_MULTU = 3'd2;
    localparam logic [2:0] C_OP_DIV   = 3'd3;
    localparam logic [2:0] C_OP_DIVU  = 3'd4;
    localparam logic [2:0] C_OP_MTHI  = 3'd5;
    localparam logic [2:0] C_OP_MTLO  = 3'd6;

    localparam logic [5:0] C_LAST_STEP = 6'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_mul_signed;
    logic        r_qsign;
    logic        r_rsign;
    logic [5:0]  r_cnt;
    logic [63:0] r_rq;       // {remainder, quotient} working register
    logic [63:0] r_result;

    logic        w_req;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_div_signed;
    logic        w_div_zero;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_rem_new;
    logic [63:0] w_rq_next;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_req        = start & ~cancel;
    assign w_is_mul     = (op == C_OP_MULT) || (op == C_OP_MULTU);
    assign w_is_div     = (op == C_OP_DIV)  || (op == C_OP_DIVU);
    assign w_div_signed = (op == C_OP_DIV);
    assign w_div_zero   = (src_b == 32'd0);
    assign w_abs_a      = (w_div_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign w_abs_b      = (w_div_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

    // ------------------------------------------------------------------
    // Multiplier: operands widened to 64 bits so the product keeps all bits
    // ------------------------------------------------------------------
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // ------------------------------------------------------------------
    // Restoring divide step. The shifted remainder needs 33 bits; when it
    // is >= divisor the difference is below 2^32, so a 32-bit subtract
    // is exact.
    // ------------------------------------------------------------------
    assign w_rem_sh   = r_rq[63:31];
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_new  = w_ge ? (w_rem_sh[31:0] - r_b) : w_rem_sh[31:0];
    assign w_rq_next  = {w_rem_new, r_rq[30:0], w_ge};
    assign w_quot_fix = r_qsign ? (~w_rq_next[31:0] + 32'd1)  : w_rq_next[31:0];
    assign w_rem_fix  = r_rsign ? (~w_rq_next[63:32] + 32'd1) : w_rq_next[63:32];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; cancel overrides everything
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (cancel) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_mul) begin
                            w_next_state = S_MUL;
                        end else if (w_is_div) begin
                            w_next_state = w_div_zero ? S_DONE : S_DIV;
                        end
                    end
                end
                S_MUL:  w_next_state = S_DONE;
                S_DIV:  w_next_state = (r_cnt == C_LAST_STEP) ? S_DONE : S_DIV;
                S_DONE: w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers. A cancelled MUL/DIV may still update r_result,
    // but the state returns to IDLE so that value is never written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_mul_signed <= 1'b0;
            r_qsign      <= 1'b0;
            r_rsign      <= 1'b0;
            r_cnt        <= 6'd0;
            r_rq         <= 64'd0;
            r_result     <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && w_is_mul) begin
                        r_a          <= src_a;
                        r_b          <= src_b;
                        r_mul_signed <= (op == C_OP_MULT);
                    end else if (w_req && w_is_div) begin
                        if (w_div_zero) begin
                            r_result <= {src_a, 32'hFFFF_FFFF};
                        end else begin
                            r_b     <= w_abs_b;
                            r_rq    <= {32'd0, w_abs_a};
                            r_qsign <= w_div_signed & (src_a[31] ^ src_b[31]);
                            r_rsign <= w_div_signed & src_a[31];
                            r_cnt   <= 6'd0;
                        end
                    end
                end
                S_MUL: begin
                    r_result <= r_mul_signed ? w_prod_s : w_prod_u;
                end
                S_DIV: begin
                    r_rq  <= w_rq_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == C_LAST_STEP) begin
                        r_result <= {w_rem_fix, w_quot_fix};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        hilo_wen   = 1'b0;
        hilo_wdata = 64'd0;
        stall      = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_is_mul || w_is_div) begin
                        stall = 1'b1;
                    end else if (op == C_OP_MTHI) begin
                        hilo_wen   = 1'b1;
                        hilo_wdata = {src_a, lo_in};
                    end else if (op == C_OP_MTLO) begin
                        hilo_wen   = 1'b1;
                        hilo_wdata = {hi_in, src_a};
                    end
                end
            end
            S_MUL, S_DIV: begin
                stall = ~cancel;
            end
            S_DONE: begin
                // start is still held here; it is deliberately ignored
                if (!cancel) begin
                    hilo_wen   = 1'b1;
                    hilo_wdata = r_result;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
